// File: rtl/sub_run_if.sv
// Handshake bundle between the test harness (master) and the sub-block run controller (slave).
interface sub_run_if #(
    parameter int NUM_SUBS = 2,
    parameter int CW       = 32
) ();
    logic                start;
    logic [NUM_SUBS-1:0] sub_done;
    logic                sub_err;
    logic                sub_reset_l;
    logic                busy;
    logic [NUM_SUBS-1:0] done_mask;
    logic [CW-1:0]       cycle_count;
    logic                finished;
    logic                pass;
    logic                timed_out;

    modport master (
        output start, sub_done, sub_err,
        input  sub_reset_l, busy, done_mask, cycle_count, finished, pass, timed_out
    );

    modport slave (
        input  start, sub_done, sub_err,
        output sub_reset_l, busy, done_mask, cycle_count, finished, pass, timed_out
    );
endinterface

// File: rtl/sub_run_ctrl.sv
// Sequences reset/run/drain of NUM_SUBS counter sub-blocks with a watchdog and a single
// pass/fail verdict; the companion checker module carries the protocol assertions.
module sub_run_ctrl #(
    parameter int NUM_SUBS     = 2,
    parameter int RST_CYCLES   = 4,
    parameter int TIMEOUT      = 100,
    parameter int DRAIN_CYCLES = 2,
    parameter int CW           = 32
) (
    input logic     clk,
    input logic     reset,
    sub_run_if.slave bus
);
    localparam int PHASE_MAX = (RST_CYCLES > DRAIN_CYCLES) ? RST_CYCLES : DRAIN_CYCLES;
    localparam int PW        = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;

    localparam logic [PW-1:0]       HOLD_LAST    = PW'(RST_CYCLES - 1);
    localparam logic [PW-1:0]       DRAIN_LAST   = PW'(DRAIN_CYCLES - 1);
    localparam logic [CW-1:0]       TIMEOUT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]       CNT_MAX      = {CW{1'b1}};
    localparam logic [NUM_SUBS-1:0] ALL_DONE     = {NUM_SUBS{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HOLD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t              state_r;
    logic [PW-1:0]       phase_cnt_r;
    logic                err_seen_r;
    logic                sub_reset_l_r;
    logic                busy_r;
    logic [NUM_SUBS-1:0] done_mask_r;
    logic [CW-1:0]       cycle_count_r;
    logic                finished_r;
    logic                pass_r;
    logic                timed_out_r;

    logic [NUM_SUBS-1:0] done_next_s;
    logic                all_done_s;
    logic                timeout_s;
    logic [CW-1:0]       cycle_next_s;

    // RUN-cycle bookkeeping: merged done mask, completion, watchdog hit, saturating count
    always_comb begin
        done_next_s  = done_mask_r | bus.sub_done;
        all_done_s   = (done_next_s == ALL_DONE);
        timeout_s    = (cycle_count_r == TIMEOUT_LAST);
        cycle_next_s = cycle_count_r;
        if (cycle_count_r != CNT_MAX) begin
            cycle_next_s = cycle_count_r + CW'(1);
        end else begin
            cycle_next_s = CNT_MAX;
        end
    end

    // Run-sequence state machine with all outputs registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            phase_cnt_r   <= {PW{1'b0}};
            err_seen_r    <= 1'b0;
            sub_reset_l_r <= 1'b0;
            busy_r        <= 1'b0;
            done_mask_r   <= {NUM_SUBS{1'b0}};
            cycle_count_r <= {CW{1'b0}};
            finished_r    <= 1'b0;
            pass_r        <= 1'b0;
            timed_out_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state_r       <= ST_HOLD;
                        phase_cnt_r   <= {PW{1'b0}};
                        err_seen_r    <= 1'b0;
                        sub_reset_l_r <= 1'b0;
                        busy_r        <= 1'b1;
                        done_mask_r   <= {NUM_SUBS{1'b0}};
                        cycle_count_r <= {CW{1'b0}};
                        finished_r    <= 1'b0;
                        pass_r        <= 1'b0;
                        timed_out_r   <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (phase_cnt_r == HOLD_LAST) begin
                        state_r       <= ST_RUN;
                        phase_cnt_r   <= {PW{1'b0}};
                        sub_reset_l_r <= 1'b1;
                    end else begin
                        phase_cnt_r <= phase_cnt_r + PW'(1);
                    end
                end
                ST_RUN: begin
                    cycle_count_r <= cycle_next_s;
                    done_mask_r   <= done_next_s;
                    err_seen_r    <= err_seen_r | bus.sub_err;
                    if (all_done_s || bus.sub_err || timeout_s) begin
                        state_r     <= ST_DRAIN;
                        phase_cnt_r <= {PW{1'b0}};
                        // Completion on the final watchdog cycle still counts as success
                        if (timeout_s && !all_done_s) begin
                            timed_out_r <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (phase_cnt_r == DRAIN_LAST) begin
                        state_r       <= ST_DONE;
                        sub_reset_l_r <= 1'b0;
                        busy_r        <= 1'b0;
                        finished_r    <= 1'b1;
                        pass_r        <= (&done_mask_r) & ~err_seen_r & ~timed_out_r;
                    end else begin
                        phase_cnt_r <= phase_cnt_r + PW'(1);
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    phase_cnt_r   <= {PW{1'b0}};
                    sub_reset_l_r <= 1'b0;
                    busy_r        <= 1'b0;
                    finished_r    <= 1'b0;
                    pass_r        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sub_reset_l = sub_reset_l_r;
    assign bus.busy        = busy_r;
    assign bus.done_mask   = done_mask_r;
    assign bus.cycle_count = cycle_count_r;
    assign bus.finished    = finished_r;
    assign bus.pass        = pass_r;
    assign bus.timed_out   = timed_out_r;
endmodule

// Protocol checker for sub_run_ctrl outputs; observes only, drives nothing.
module sub_run_ctrl_chk (
    input logic clk,
    input logic reset,
    input logic start,
    input logic sub_reset_l,
    input logic busy,
    input logic finished,
    input logic pass,
    input logic timed_out
);
    a_busy_finished_excl: assert property (@(posedge clk) disable iff (reset) !(busy && finished));
    // Subs are only released while sequencing (RUN/DRAIN are both busy, never finished)
    a_release_only_busy: assert property (@(posedge clk) disable iff (reset) sub_reset_l |-> (busy && !finished));

    c_pass_reached:    cover property (@(posedge clk) disable iff (reset) pass);
    c_timeout_reached: cover property (@(posedge clk) disable iff (reset) timed_out);
    c_restart_done:    cover property (@(posedge clk) disable iff (reset) (finished && start) ##1 busy);
endmodule
